// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG IDCODE reader and the TAP state model.
// Optional comparator against EXPECTED_IDCODE is enabled by JTAG_IDCODE_COMPARE_EN.
package jtag_pkg;

   typedef enum logic [3:0] {
      TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAPTURE_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
      TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPDATE_DR, TAP_SEL_IR, TAP_CAPTURE_IR,
      TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPDATE_IR
   } tap_state_t;

   typedef enum logic [2:0] {
      RD_IDLE, RD_RESET_TAP, RD_TO_SHIFT, RD_SHIFT, RD_TO_IDLE, RD_DONE
   } reader_state_t;

   localparam int IDCODE_LEN       = 32;
   localparam int RESET_TMS_CYCLES = 5;
   localparam int TOTAL_CYCLES     = 43;
   localparam int SHIFT_FIRST      = 10;
   localparam int SHIFT_LAST       = 41;

   localparam int VER_W   = 4;
   localparam int PART_W  = 16;
   localparam int MANUF_W = 11;

   // version 1, part 1, manufacturer 1, mandatory bit0 = 1
   localparam logic [IDCODE_LEN-1:0] EXPECTED_IDCODE =
      {VER_W'(1), PART_W'(1), MANUF_W'(1), 1'b1};

   // TMS value driven during program cycle k (1-based)
   function automatic logic tms_for_cycle(input logic [5:0] k);
      return (k >= 6'd1 && k <= 6'(RESET_TMS_CYCLES)) || (k == 6'd7) ||
             (k == 6'(SHIFT_LAST)) || (k == 6'(SHIFT_LAST + 1));
   endfunction

endpackage

// File: rtl/jtag_idcode_reader_tap_model.sv
// IEEE 1149.1 TAP controller state tracker; also usable on the device side.
module tap_state_model
   import jtag_pkg::*;
(
   input  logic       i_tck,
   input  logic       i_trst_n,
   input  logic       i_tms,
   output tap_state_t o_state
);

   tap_state_t r_state;
   tap_state_t w_state_nxt;

   always_ff @(posedge i_tck or negedge i_trst_n) begin
      if (!i_trst_n) r_state <= TAP_TLR;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TAP_TLR:        w_state_nxt = i_tms ? TAP_TLR      : TAP_RTI;
         TAP_RTI:        w_state_nxt = i_tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:     w_state_nxt = i_tms ? TAP_SEL_IR   : TAP_CAPTURE_DR;
         TAP_CAPTURE_DR: w_state_nxt = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR:   w_state_nxt = i_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_EXIT1_DR:   w_state_nxt = i_tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
         TAP_PAUSE_DR:   w_state_nxt = i_tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_EXIT2_DR:   w_state_nxt = i_tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
         TAP_UPDATE_DR:  w_state_nxt = i_tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_IR:     w_state_nxt = i_tms ? TAP_TLR      : TAP_CAPTURE_IR;
         TAP_CAPTURE_IR: w_state_nxt = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR:   w_state_nxt = i_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_IR:   w_state_nxt = i_tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
         TAP_PAUSE_IR:   w_state_nxt = i_tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_IR:   w_state_nxt = i_tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
         TAP_UPDATE_IR:  w_state_nxt = i_tms ? TAP_SEL_DR   : TAP_RTI;
         default:        w_state_nxt = TAP_TLR;
      endcase
   end

   assign o_state = r_state;

endmodule

// File: rtl/jtag_idcode_reader.sv
// JTAG initiator: resets the target TAP, shifts out the 32-bit IDCODE and validates it.
// Define JTAG_IDCODE_COMPARE_EN to add the o_match port and the EXPECTED_IDCODE check.
module jtag_idcode_reader
   import jtag_pkg::*;
(
   input  logic        i_tck,
   input  logic        i_trst_n,
   input  logic        i_start,
   input  logic        i_tdo,
   output logic        o_tms,
   output logic        o_tdi,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_idcode,
   output logic        o_error
`ifdef JTAG_IDCODE_COMPARE_EN
   ,
   output logic        o_match
`endif
);

   reader_state_t r_state, w_state_nxt;
   logic [5:0]    r_cnt, w_cnt_nxt;
   logic [4:0]    r_shcnt;
   logic          r_tms, w_tms_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;
   logic [31:0]   r_sr, r_idcode;
   logic          r_error, r_model_err;
   logic          w_accept, w_sample, w_finish, w_err;
   logic [5:0]    w_cnt_inc;
   tap_state_t    w_tap;

   tap_state_model u_tap (
      .i_tck    (i_tck),
      .i_trst_n (i_trst_n),
      .i_tms    (r_tms),
      .o_state  (w_tap)
   );

   assign w_cnt_inc = r_cnt + 6'd1;

   always_ff @(posedge i_tck or negedge i_trst_n) begin
      if (!i_trst_n) begin
         r_state <= RD_IDLE;
         r_cnt   <= 6'd0;
         r_tms   <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tms   <= w_tms_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // r_cnt holds k during cycle k; TMS for cycle k+1 is registered at E_k
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_cnt_inc;
      w_tms_nxt   = tms_for_cycle(w_cnt_inc);
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_accept    = 1'b0;
      w_sample    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         RD_IDLE, RD_DONE: begin
            w_cnt_nxt = r_cnt;
            w_tms_nxt = r_tms;
            if (r_state == RD_DONE) w_state_nxt = RD_IDLE;
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = RD_RESET_TAP;
               w_cnt_nxt   = 6'd1;
               w_tms_nxt   = tms_for_cycle(6'd1);
               w_busy_nxt  = 1'b1;
            end
         end
         RD_RESET_TAP:
            if (r_cnt == 6'(RESET_TMS_CYCLES)) w_state_nxt = RD_TO_SHIFT;
         RD_TO_SHIFT:
            if (r_cnt == 6'(SHIFT_FIRST - 1)) w_state_nxt = RD_SHIFT;
         RD_SHIFT: begin
            w_sample = 1'b1;
            if (r_shcnt == 5'd31) w_state_nxt = RD_TO_IDLE;
         end
         RD_TO_IDLE:
            if (r_cnt == 6'(TOTAL_CYCLES)) begin
               w_finish    = 1'b1;
               w_state_nxt = RD_DONE;
               w_cnt_nxt   = 6'd0;
               w_tms_nxt   = 1'b0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end
         default: w_state_nxt = RD_IDLE;
      endcase
   end

`ifdef JTAG_IDCODE_COMPARE_EN
   logic r_match, w_match;
   assign w_match = (r_sr == EXPECTED_IDCODE);
   assign w_err   = ~r_sr[0] | (&r_sr) | r_model_err | ~w_match;
   assign o_match = r_match;
`else
   assign w_err   = ~r_sr[0] | (&r_sr) | r_model_err;
`endif

   always_ff @(posedge i_tck or negedge i_trst_n) begin
      if (!i_trst_n) begin
         r_shcnt     <= 5'd0;
         r_sr        <= '0;
         r_idcode    <= '0;
         r_error     <= 1'b0;
         r_model_err <= 1'b0;
`ifdef JTAG_IDCODE_COMPARE_EN
         r_match     <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_shcnt     <= 5'd0;
            r_model_err <= 1'b0;
         end
         // TDO enters at the top so the first sample ends up in bit 0
         if (w_sample) begin
            r_sr    <= {i_tdo, r_sr[31:1]};
            r_shcnt <= r_shcnt + 5'd1;
            if (w_tap != TAP_SHIFT_DR) r_model_err <= 1'b1;
         end
         if (w_finish) begin
            r_idcode <= r_sr;
            r_error  <= w_err;
`ifdef JTAG_IDCODE_COMPARE_EN
            r_match  <= w_match;
`endif
         end
      end
   end

   assign o_tms    = r_tms;
   assign o_tdi    = 1'b0;
   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_idcode = r_idcode;
   assign o_error  = r_error;

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Scoreboard bench: a behavioural target TAP returns a programmable IDCODE.
module tb_jtag_idcode_reader;
   import jtag_pkg::*;

   logic        tck, trst_n, start, tdo;
   logic        tms, tdi, busy, done, error;
   logic [31:0] idcode;
`ifdef JTAG_IDCODE_COMPARE_EN
   logic        match;
`endif

   jtag_idcode_reader dut (
      .i_tck    (tck),
      .i_trst_n (trst_n),
      .i_start  (start),
      .i_tdo    (tdo),
      .o_tms    (tms),
      .o_tdi    (tdi),
      .o_busy   (busy),
      .o_done   (done),
      .o_idcode (idcode),
      .o_error  (error)
`ifdef JTAG_IDCODE_COMPARE_EN
      ,
      .o_match  (match)
`endif
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   int cyc = 0;
   always @(posedge tck) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural target TAP ----------------
   logic [31:0] tgt_code;
   bit          tgt_ones;
   tap_state_t  ts;
   logic [31:0] dr;

   function automatic tap_state_t tgt_next(input tap_state_t s, input logic m);
      case (s)
         TAP_TLR:        return m ? TAP_TLR : TAP_RTI;
         TAP_RTI:        return m ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_DR:     return m ? TAP_SEL_IR : TAP_CAPTURE_DR;
         TAP_CAPTURE_DR: return m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR:   return m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_EXIT1_DR:   return m ? TAP_UPDATE_DR : TAP_PAUSE_DR;
         TAP_PAUSE_DR:   return m ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_EXIT2_DR:   return m ? TAP_UPDATE_DR : TAP_SHIFT_DR;
         TAP_UPDATE_DR:  return m ? TAP_SEL_DR : TAP_RTI;
         TAP_SEL_IR:     return m ? TAP_TLR : TAP_CAPTURE_IR;
         TAP_CAPTURE_IR: return m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR:   return m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_IR:   return m ? TAP_UPDATE_IR : TAP_PAUSE_IR;
         TAP_PAUSE_IR:   return m ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_IR:   return m ? TAP_UPDATE_IR : TAP_SHIFT_IR;
         default:        return m ? TAP_SEL_DR : TAP_RTI;
      endcase
   endfunction

   always @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         ts <= TAP_TLR;
         dr <= '0;
      end else begin
         if (ts == TAP_CAPTURE_DR)    dr <= tgt_code;
         else if (ts == TAP_SHIFT_DR) dr <= {1'b1, dr[31:1]};
         ts <= tgt_next(ts, tms);
      end
   end

   always @(negedge tck) tdo <= tgt_ones ? 1'b1 : dr[0];

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] id;
      bit          err;
      bit          m;
      int          cyc;
   } exp_t;
   exp_t q[$];

   always @(negedge tck) begin
      if (trst_n && done) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: done high at cycle %0d, expected none", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("idcode", idcode, e.id);
            chk("error", {31'd0, error}, {31'd0, e.err});
`ifdef JTAG_IDCODE_COMPARE_EN
            chk("match", {31'd0, match}, {31'd0, e.m});
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic bit tms_exp(input int k);
      if (k >= 1 && k <= 5) return 1'b1;
      if (k == 7 || k == 41 || k == 42) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t mk_exp(input logic [31:0] code, input bit ones, input int dcyc);
      exp_t e;
      e.id  = ones ? 32'hFFFF_FFFF : code;
      e.err = (e.id[0] == 1'b0) || (e.id == 32'hFFFF_FFFF);
      e.m   = (e.id == 32'h1000_1003);
`ifdef JTAG_IDCODE_COMPARE_EN
      if (!e.m) e.err = 1'b1;
`endif
      e.cyc = dcyc;
      return e;
   endfunction

   task automatic run_read(input logic [31:0] code, input bit ones, input int abort_k);
      int c0, tms_bad, busy_bad;
      tgt_code = code;
      tgt_ones = ones;
      @(negedge tck);
      start = 1'b1;
      @(posedge tck);
      #1;
      c0 = cyc;
      start = 1'b0;
      if (abort_k == 0) q.push_back(mk_exp(code, ones, c0 + 43));
      tms_bad  = 0;
      busy_bad = 0;
      for (int k = 1; k <= 43; k++) begin
         if (k == abort_k) begin
            @(negedge tck);
            trst_n = 1'b0;
            #1;
            chk("abort_tms", {31'd0, tms}, 32'd1);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_idcode", idcode, 32'd0);
            chk("abort_done", {31'd0, done}, 32'd0);
            repeat (2) @(negedge tck);
            trst_n = 1'b1;
            return;
         end
         if (tms !== tms_exp(k)) begin
            tms_bad++;
            if (tms_bad == 1) $display("tms diverges at program cycle %0d", k);
         end
         if (busy !== 1'b1) busy_bad++;
         @(posedge tck);
         #1;
      end
      chk("tms_program", 32'(tms_bad), 32'd0);
      chk("busy_window", 32'(busy_bad), 32'd0);
      chk("idle_tms", {31'd0, tms}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("tdi_zero", {31'd0, tdi}, 32'd0);
   endtask

   task automatic run_back_to_back();
      int c0;
      tgt_code = 32'h1000_1003;
      tgt_ones = 1'b0;
      @(negedge tck);
      start = 1'b1;
      @(posedge tck);
      #1;
      c0 = cyc;
      q.push_back(mk_exp(32'h1000_1003, 1'b0, c0 + 43));
      q.push_back(mk_exp(32'h1000_1003, 1'b0, c0 + 87));
      repeat (88) @(negedge tck);
      start = 1'b0;
      @(posedge tck);
      #1;
      chk("b2b_no_third", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      trst_n   = 1'b1;
      start    = 1'b0;
      tgt_code = '0;
      tgt_ones = 1'b0;
      #1 trst_n = 1'b0;
      repeat (2) @(negedge tck);
      #1;
      chk("rst_tms", {31'd0, tms}, 32'd1);
      chk("rst_tdi", {31'd0, tdi}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_idcode", idcode, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
`ifdef JTAG_IDCODE_COMPARE_EN
      chk("rst_match", {31'd0, match}, 32'd0);
`endif
      @(negedge tck);
      trst_n = 1'b1;
      repeat (2) @(negedge tck);

      run_read(32'h1000_1003, 1'b0, 0);
      run_read(32'h0000_0000, 1'b1, 0);
      run_read(32'h1000_1002, 1'b0, 0);
      run_read(32'hA5A5_5A5B, 1'b0, 0);
      run_read(32'h1000_1003, 1'b0, 20);
      run_read(32'h1000_1003, 1'b0, 0);
      run_back_to_back();

      repeat (4) @(negedge tck);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
